// File: rtl/ccr_stack.sv
// ccr_stack
// Condition-code register with a LIFO save stack. Nested interrupts can
// preserve the live flags across handlers and get them back on RTI.
//
// Ports:
//   i_clk       clock, all state changes on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_flags_in  flag values produced by the ALU
//   i_flag_we   per-flag write enable for i_flags_in
//   i_set_mask  flags forced to 1 (SETC)
//   i_clr_mask  flags forced to 0 (CLRC); clear beats set on the same bit
//   i_save      interrupt entry: push the live flags
//   i_restore   RTI: pop the top entry into the live flags
//   i_err_clr   clears the sticky overflow/underflow flags
//   o_ccr_out   live flags, registered ([V C N Z] at FLAG_W=4, LSB = Z)
//   o_depth     number of occupied stack entries
//   o_full      stack holds DEPTH entries
//   o_empty     stack holds no entries
//   o_ovf_err   sticky: save was attempted while the stack was full
//   o_unf_err   sticky: restore was attempted while the stack was empty
module ccr_stack #(
    parameter int FLAG_W        = 4,
    parameter int DEPTH         = 4,
    parameter bit CLEAR_ON_SAVE = 1'b0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [FLAG_W-1:0]          i_flags_in,
    input  logic [FLAG_W-1:0]          i_flag_we,
    input  logic [FLAG_W-1:0]          i_set_mask,
    input  logic [FLAG_W-1:0]          i_clr_mask,
    input  logic                       i_save,
    input  logic                       i_restore,
    input  logic                       i_err_clr,
    output logic [FLAG_W-1:0]          o_ccr_out,
    output logic [$clog2(DEPTH+1)-1:0] o_depth,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_ovf_err,
    output logic                       o_unf_err
);

    localparam int DW = $clog2(DEPTH+1);

    logic [FLAG_W-1:0] r_ccr;
    logic [FLAG_W-1:0] r_stack [DEPTH];
    logic [DW-1:0]     r_depth;
    logic              r_ovf_err;
    logic              r_unf_err;

    logic              w_full;
    logic              w_empty;
    logic              w_save_only;
    logic              w_restore_only;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_event;
    logic              w_unf_event;
    logic [FLAG_W-1:0] w_top;
    logic [FLAG_W-1:0] w_alu_merged;
    logic [FLAG_W-1:0] w_normal_next;
    logic [FLAG_W-1:0] w_ccr_next;

    assign w_full  = (r_depth == DW'(DEPTH));
    assign w_empty = (r_depth == '0);

    // save and restore together cancel each other, so only the "alone"
    // cases ever touch the stack or raise an error.
    assign w_save_only    = i_save & ~i_restore;
    assign w_restore_only = i_restore & ~i_save;
    assign w_push         = w_save_only & ~w_full;
    assign w_pop          = w_restore_only & ~w_empty;
    assign w_ovf_event    = w_save_only & w_full;
    assign w_unf_event    = w_restore_only & w_empty;

    // Top-of-stack read, stack[depth-1]; nothing valid to read when empty.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_depth == DW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    // Normal update: masked ALU merge, then SETC, then CLRC so clear wins.
    assign w_alu_merged  = (r_ccr & ~i_flag_we) | (i_flags_in & i_flag_we);
    assign w_normal_next = (w_alu_merged | i_set_mask) & ~i_clr_mask;

    // Next live flags. Any lone save or restore (successful or not)
    // suppresses the ALU/SETC/CLRC path for that cycle.
    always_comb begin
        w_ccr_next = r_ccr;
        if (w_pop) begin
            w_ccr_next = w_top;
        end else if (w_push) begin
            w_ccr_next = CLEAR_ON_SAVE ? '0 : r_ccr;
        end else if (!w_save_only && !w_restore_only) begin
            w_ccr_next = w_normal_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ccr     <= '0;
            r_depth   <= '0;
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_ccr <= w_ccr_next;
            if (w_push) begin
                r_depth <= r_depth + DW'(1);
            end else if (w_pop) begin
                r_depth <= r_depth - DW'(1);
            end
            // Only the slot just above the current top is written on a push.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_depth == DW'(i))) begin
                    r_stack[i] <= r_ccr;
                end
            end
            // A new error event outranks err_clr in the same cycle.
            r_ovf_err <= w_ovf_event | (r_ovf_err & ~i_err_clr);
            r_unf_err <= w_unf_event | (r_unf_err & ~i_err_clr);
        end
    end

    assign o_ccr_out = r_ccr;
    assign o_depth   = r_depth;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_ovf_err = r_ovf_err;
    assign o_unf_err = r_unf_err;

endmodule

// File: doc/ccr_stack.md
Name: ccr_stack

Overview:
- Parametrised condition-code register for the pipelined processor, with a LIFO save stack so nested interrupts preserve flags.
- Holds FLAG_W live flags, packed [V C N Z] at FLAG_W=4, LSB = Z.
- Supports per-flag masked ALU updates, explicit flag set/clear (SETC/CLRC), push on interrupt entry and pop on RTI.
- Sits beside the execute stage. It is fed by the ALU flag outputs and the controller, and its output feeds branch-condition logic.

Parameters:
- FLAG_W, 4, number of condition flags.
- DEPTH, 4, number of save-stack entries (maximum interrupt nesting), must be >= 1.
- CLEAR_ON_SAVE, 0, if 1 the live flags clear to 0 on a successful save; if 0 they hold.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flags_in  in  FLAG_W  combinational flags from ALU.
- flag_we  in  FLAG_W  per-bit update enable for flags_in.
- set_mask  in  FLAG_W  bits to force to 1 (SETC).
- clr_mask  in  FLAG_W  bits to force to 0 (CLRC).
- save  in  1  interrupt entry, push live flags.
- restore  in  1  RTI, pop top entry into live flags.
- err_clr  in  1  clears sticky error flags.
- ccr_out  out  FLAG_W  live flags (registered).
- depth  out  $clog2(DEPTH+1)  number of occupied stack entries.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- ovf_err  out  1  sticky, save attempted while full.
- unf_err  out  1  sticky, restore attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ccr_out=0, depth=0, all stack entries=0, ovf_err=0, unf_err=0.
  - Hence empty=1, full=0.
  - Deassertion is sampled at clk.
- Latency: all outputs are registered. An input at edge N is visible on ccr_out/depth after edge N.
- Operation priority per cycle, highest first:
  - save and restore both high: no stack operation, depth unchanged, no error. The normal update applies.
  - restore only, not empty: ccr_out <= stack[depth-1], depth <= depth-1. flags_in, set_mask and clr_mask are ignored this cycle.
  - restore only, empty: ccr_out holds, depth stays 0, unf_err <= 1.
  - save only, not full:
    - stack[depth] <= current ccr_out (the pre-edge value), depth <= depth+1.
    - ccr_out <= 0 if CLEAR_ON_SAVE=1, else holds. The ALU update and set/clear are ignored.
  - save only, full: no push, no stack corruption, ccr_out holds, ovf_err <= 1.
  - Neither (normal update):
    - t = (ccr_out & ~flag_we) | (flags_in & flag_we).
    - ccr_out <= (t | set_mask) & ~clr_mask.
    - A bit in both set_mask and clr_mask resolves to 0 (clear wins).
    - flag_we=0 with set_mask=clr_mask=0 holds ccr_out.
- Stack:
  - Strict LIFO.
  - Entries at index >= depth are don't-care and are never read.
  - depth never exceeds DEPTH and never wraps below 0.
- Sticky errors:
  - Set as above, cleared only by err_clr or reset.
  - err_clr in the same cycle as a new error event: the error wins (flag stays 1).
- full and empty are combinational decodes of the depth register.
- Reset mid-operation (for example at depth=3) immediately returns all state to its reset values. Stacked contents are lost.
- No X propagation: all storage is reset.

Test Plan:
- Reset, then flag_we=4'b1111 with flags_in=4'b1010 -> next cycle ccr_out=4'b1010; then flag_we=4'b0001 with flags_in=4'b0101 -> ccr_out=4'b1011.
- ccr_out=4'b0000, set_mask=4'b0110, clr_mask=4'b0100 -> ccr_out=4'b0010 (clear wins on bit 2).
- Nested interrupts, CLEAR_ON_SAVE=0:
  - Sequence: load 4'h1, save, load 4'h2, save, load 4'h3, save.
  - After the third save: depth=3, ccr_out=4'h3.
  - Three restores then yield ccr_out 4'h3, 4'h2, 4'h1 with depth 2, 1, 0 (each restore pops the flags saved by the matching save).
- Push to full (DEPTH=4), then one more save -> depth stays 4, full=1, ovf_err=1, ccr_out unchanged; err_clr -> ovf_err=0.
- Restore while empty -> unf_err=1, ccr_out unchanged; save+restore together at depth=2 with flag_we=4'hF, flags_in=4'h9 -> depth=2, ccr_out=4'h9.
- At depth=3 with ccr_out=4'h7, assert rst_n=0 between clock edges -> ccr_out=0, depth=0, empty=1 immediately, without waiting for a clock edge.
